// File: rtl/fir_filter.sv
// fir_filter: decimating direct-form FIR filter, signed Q1.15 samples and coefficients.
//   clk       rising-edge clock for all state
//   rst_n     asynchronous active-high reset (clears history, counter and outputs)
//   R         output decimation ratio, 0 behaves as 1
//   x_input   signed Q1.15 input sample, taken when valid_in is high
//   valid_in  x_input is valid this cycle
//   y_output  registered signed Q1.15 output, held between valid_out pulses
//   valid_out single-cycle pulse marking a new y_output
// Coefficients come from COEFF_INIT (h[k] in bits [k*COEFF_WIDTH +: COEFF_WIDTH]).
module fir_filter #(
    parameter int N_MAX = 92,
    parameter int WIDTH = 16,
    parameter int COEFF_WIDTH = 16,
    parameter bit LOAD_FILE = 1'b1,
    parameter logic [N_MAX*COEFF_WIDTH-1:0] COEFF_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       R,
    input  logic [WIDTH-1:0] x_input,
    input  logic             valid_in,
    output logic [WIDTH-1:0] y_output,
    output logic             valid_out
);
    localparam int PW = WIDTH + COEFF_WIDTH;
    localparam int AW = PW + $clog2(N_MAX);
    localparam int SH = COEFF_WIDTH - 1;
    localparam logic signed [AW-1:0] RND = AW'(1) << (SH - 1);
    localparam logic signed [AW-1:0] YMAX = AW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] YMIN = -YMAX - AW'(1);

    logic signed [COEFF_WIDTH-1:0] h [N_MAX];
    logic signed [WIDTH-1:0] x [N_MAX];
    logic [4:0] cnt, r_last, r_eff, cur;
    logic v1;
    logic signed [AW-1:0] acc, rnd;
    logic [WIDTH-1:0] y_next;

    // Coefficient ROM contents fixed at elaboration.
    initial begin
        for (int i = 0; i < N_MAX; i++) h[i] = COEFF_INIT[i*COEFF_WIDTH +: COEFF_WIDTH];
    end

    assign r_eff = (R == 5'd0) ? 5'd1 : R;
    // A ratio different from the one seen on the previous accepted sample restarts the phase at 0.
    assign cur = (r_eff != r_last) ? 5'd0 : cnt;

    // Stage 1: shift in the sample and mark whether it is a decimation keeper.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_MAX; i++) x[i] <= '0;
            cnt <= '0;
            r_last <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= valid_in && cur == 5'd0;
            if (valid_in) begin
                x[0] <= x_input;
                for (int i = 1; i < N_MAX; i++) x[i] <= x[i-1];
                cnt <= (cur + 5'd1 == r_eff) ? 5'd0 : cur + 5'd1;
                r_last <= r_eff;
            end
        end
    end

    // Full-precision MAC over the updated history, then round half up and saturate.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_MAX; i++) acc = acc + AW'(h[i]) * AW'(x[i]);
        rnd = (acc + RND) >>> SH;
        y_next = rnd > YMAX ? YMAX[WIDTH-1:0] : rnd < YMIN ? YMIN[WIDTH-1:0] : rnd[WIDTH-1:0];
    end

    // Stage 2: output register, only updated for kept samples.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            y_output <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= v1;
            if (v1) y_output <= y_next;
        end
    end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed self-checking bench for fir_filter (92-tap main instance, 4-tap saturation instance).
module tb_fir_filter;
    function automatic int hc(input int k);
        return k * 37 - 1500;
    endfunction

    function automatic logic [92*16-1:0] make_coeffs();
        logic [92*16-1:0] c;
        c = '0;
        for (int k = 0; k < 92; k++) c[k*16 +: 16] = 16'(hc(k));
        return c;
    endfunction

    localparam logic [92*16-1:0] COEFFS = make_coeffs();
    localparam logic [4*16-1:0] SAT_COEFFS = {4{16'h4000}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] R = 5'd1;
    logic [15:0] x_input = '0;
    logic valid_in = 1'b0;
    logic [15:0] y_output;
    logic valid_out;
    logic [4:0] rs = 5'd1;
    logic [15:0] xs = '0;
    logic vs = 1'b0;
    logic [15:0] ys;
    logic vos;

    int tests = 0;
    int fails = 0;

    logic stim_v [256];
    logic [15:0] stim_x [256];
    logic [4:0] stim_r [256];
    logic obs_v [260];
    logic [15:0] obs_y [260];

    fir_filter #(.N_MAX(92), .WIDTH(16), .COEFF_WIDTH(16), .LOAD_FILE(1'b0), .COEFF_INIT(COEFFS)) dut (
        .clk(clk), .rst_n(rst_n), .R(R), .x_input(x_input), .valid_in(valid_in),
        .y_output(y_output), .valid_out(valid_out)
    );

    fir_filter #(.N_MAX(4), .WIDTH(16), .COEFF_WIDTH(16), .LOAD_FILE(1'b0), .COEFF_INIT(SAT_COEFFS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .R(rs), .x_input(xs), .valid_in(vs),
        .y_output(ys), .valid_out(vos)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference output for stimulus index j, starting from an all-zero history.
    function automatic logic [15:0] ref_y(input int j);
        longint acc;
        int k;
        acc = 0;
        k = 0;
        for (int i = j; i >= 0 && k < 92; i--) begin
            if (stim_v[i]) begin
                acc += longint'(hc(k)) * longint'($signed(stim_x[i]));
                k++;
            end
        end
        acc = (acc + 16384) >>> 15;
        return acc > 32767 ? 16'h7fff : acc < -32768 ? 16'h8000 : 16'(acc);
    endfunction

    task automatic do_reset();
        valid_in = 1'b0;
        vs = 1'b0;
        R = 5'd1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Drives stim[0..n-1] one per cycle and records outputs; sample j shows up in obs[j+2].
    task automatic run_stream(input int n);
        for (int j = 0; j < n + 3; j++) begin
            @(negedge clk);
            obs_v[j] = valid_out;
            obs_y[j] = y_output;
            valid_in = j < n ? stim_v[j] : 1'b0;
            x_input = j < n ? stim_x[j] : 16'h0000;
            R = j < n ? stim_r[j] : R;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b1;
        #1;
        tests++; if (y_output !== 16'h0000) begin fails++; $display("FAIL reset_y: got %h expected 0000", y_output); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        tests++; if (ys !== 16'h0000 || vos !== 1'b0) begin fails++; $display("FAIL reset_sat: got %h/%b expected 0000/0", ys, vos); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", valid_out); end
    endtask

    task automatic test_impulse();
        logic [15:0] e;
        do_reset();
        for (int j = 0; j < 96; j++) begin
            stim_v[j] = 1'b1;
            stim_x[j] = j == 0 ? 16'h4000 : 16'h0000;
            stim_r[j] = 5'd1;
        end
        run_stream(96);
        tests++; if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b0) begin fails++; $display("FAIL impulse_latency: got %b%b expected 00", obs_v[0], obs_v[1]); end
        for (int j = 0; j < 96; j++) begin
            e = j < 92 ? 16'((hc(j) * 16384 + 16384) >>> 15) : 16'h0000;
            tests++; if (obs_v[j+2] !== 1'b1) begin fails++; $display("FAIL impulse_valid[%0d]: got %b expected 1", j, obs_v[j+2]); end
            tests++; if (obs_y[j+2] !== e) begin fails++; $display("FAIL impulse_y[%0d]: got %h expected %h", j, obs_y[j+2], e); end
        end
        tests++; if (obs_v[98] !== 1'b0) begin fails++; $display("FAIL impulse_tail_valid: got %b expected 0", obs_v[98]); end
    endtask

    task automatic test_dc_step();
        do_reset();
        for (int j = 0; j < 120; j++) begin
            stim_v[j] = 1'b1;
            stim_x[j] = 16'h4000;
            stim_r[j] = 5'd1;
        end
        run_stream(120);
        tests++; if (obs_y[2] !== 16'hfd12) begin fails++; $display("FAIL dc_first: got %h expected fd12", obs_y[2]); end
        for (int j = 91; j < 120; j++) begin
            tests++; if (obs_y[j+2] !== 16'h20f9) begin fails++; $display("FAIL dc_settled[%0d]: got %h expected 20f9", j, obs_y[j+2]); end
        end
    endtask

    task automatic test_gapped();
        logic [15:0] e;
        do_reset();
        for (int j = 0; j < 60; j++) begin
            stim_v[j] = j % 2 == 0;
            stim_x[j] = 16'(j * 400 - 12000);
            stim_r[j] = 5'd1;
        end
        run_stream(60);
        for (int j = 0; j < 60; j++) begin
            tests++; if (obs_v[j+2] !== stim_v[j]) begin fails++; $display("FAIL gapped_valid[%0d]: got %b expected %b", j, obs_v[j+2], stim_v[j]); end
            if (stim_v[j]) begin
                e = ref_y(j);
                tests++; if (obs_y[j+2] !== e) begin fails++; $display("FAIL gapped_y[%0d]: got %h expected %h", j, obs_y[j+2], e); end
            end
        end
    endtask

    task automatic test_decimation();
        logic [15:0] last;
        int pulses;
        do_reset();
        for (int j = 0; j < 128; j++) begin
            stim_v[j] = 1'b1;
            stim_x[j] = 16'(j * 517 - 30000);
            stim_r[j] = 5'd4;
        end
        run_stream(128);
        pulses = 0;
        last = 16'h0000;
        for (int j = 0; j < 131; j++) pulses += int'(obs_v[j]);
        tests++; if (pulses != 32) begin fails++; $display("FAIL decim_count: got %0d expected 32", pulses); end
        for (int j = 0; j < 128; j++) begin
            if (j % 4 == 0) last = ref_y(j);
            tests++; if (obs_v[j+2] !== (j % 4 == 0)) begin fails++; $display("FAIL decim_valid[%0d]: got %b expected %b", j, obs_v[j+2], j % 4 == 0); end
            tests++; if (obs_y[j+2] !== last) begin fails++; $display("FAIL decim_y[%0d]: got %h expected %h", j, obs_y[j+2], last); end
        end
    endtask

    task automatic test_r_change();
        logic [13:0] pat;
        logic [15:0] e;
        pat = 14'b11111010101001;
        do_reset();
        for (int j = 0; j < 14; j++) begin
            stim_v[j] = 1'b1;
            stim_x[j] = 16'(j * 1111 - 5000);
            stim_r[j] = j < 5 ? 5'd3 : j < 10 ? 5'd2 : 5'd0;
        end
        run_stream(14);
        for (int j = 0; j < 14; j++) begin
            tests++; if (obs_v[j+2] !== pat[j]) begin fails++; $display("FAIL rchange_valid[%0d]: got %b expected %b", j, obs_v[j+2], pat[j]); end
            if (pat[j]) begin
                e = ref_y(j);
                tests++; if (obs_y[j+2] !== e) begin fails++; $display("FAIL rchange_y[%0d]: got %h expected %h", j, obs_y[j+2], e); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            x_input = 16'h4000;
        end
        @(negedge clk);
        tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid: got %b expected 1", valid_out); end
        #2 rst_n = 1'b1;
        #1;
        tests++; if (y_output !== 16'h0000) begin fails++; $display("FAIL midrst_y: got %h expected 0000", y_output); end
        tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int j = 0; j < 6; j++) begin
            stim_v[j] = 1'b1;
            stim_x[j] = j == 0 ? 16'h4000 : 16'h0000;
            stim_r[j] = 5'd1;
        end
        run_stream(6);
        tests++; if (obs_v[0] !== 1'b0 || obs_v[1] !== 1'b0) begin fails++; $display("FAIL midrst_latency: got %b%b expected 00", obs_v[0], obs_v[1]); end
        for (int j = 0; j < 6; j++) begin
            e = ref_y(j);
            tests++; if (obs_v[j+2] !== 1'b1 || obs_y[j+2] !== e) begin fails++; $display("FAIL midrst_out[%0d]: got %b/%h expected 1/%h", j, obs_v[j+2], obs_y[j+2], e); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            obs_y[j] = ys;
            obs_v[j] = vos;
            vs = j < 16;
            xs = j < 8 ? 16'h7fff : 16'h8000;
        end
        vs = 1'b0;
        tests++; if (obs_v[2] !== 1'b1 || obs_y[2] !== 16'h4000) begin fails++; $display("FAIL sat_first: got %b/%h expected 1/4000", obs_v[2], obs_y[2]); end
        tests++; if (obs_y[9] !== 16'h7fff) begin fails++; $display("FAIL sat_pos: got %h expected 7fff", obs_y[9]); end
        tests++; if (obs_y[11] !== 16'hffff) begin fails++; $display("FAIL sat_cross: got %h expected ffff", obs_y[11]); end
        tests++; if (obs_y[17] !== 16'h8000) begin fails++; $display("FAIL sat_neg: got %h expected 8000", obs_y[17]); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_step();
        test_gapped();
        test_decimation();
        test_r_change();
        test_reset_midstream();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 SHALL provide parameter N_MAX, default 92: number of filter taps.
REQ-002 SHALL provide parameter WIDTH, default 16: input/output sample width, signed Q1.15.
REQ-003 SHALL provide parameter COEFF_WIDTH, default 16: coefficient width, signed Q1.15.
REQ-004 SHALL provide port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port R, input, 5 bits: output decimation ratio, unsigned.
REQ-007 SHALL provide port x_input, input, WIDTH bits: signed Q1.15 input sample.
REQ-008 SHALL provide port valid_in, input, 1 bit: x_input is valid this cycle.
REQ-009 SHALL provide port y_output, output, WIDTH bits: signed Q1.15 filtered sample, registered.
REQ-010 SHALL provide port valid_out, output, 1 bit: y_output is valid this cycle, single-cycle pulse.

Function
REQ-011 SHALL hold N_MAX signed COEFF_WIDTH coefficients h[0..N_MAX-1] in an internal ROM, loaded at elaboration by $readmemh from "coeff_FIR.txt", one hex word per line, h[0] first.
REQ-012 SHALL keep an N_MAX-entry delay line x[0..N_MAX-1]; on each cycle with valid_in=1, x[0]<=x_input and x[k]<=x[k-1].
REQ-013 SHALL leave the delay line, decimation counter and outputs unchanged on cycles with valid_in=0 (no handshake back-pressure; every valid_in=1 cycle is accepted).
REQ-014 SHALL compute, for each accepted sample, acc = sum over k of h[k]*x[k] using the updated delay line; products full precision Q2.30 (WIDTH+COEFF_WIDTH bits); accumulator WIDTH+COEFF_WIDTH+ceil(log2(N_MAX)) bits (39 at defaults), no internal truncation.
REQ-015 SHALL convert acc to the output by adding 2^14 (round half up), arithmetic-shifting right by 15, then saturating to [-32768, +32767].
REQ-016 SHALL present y_output and assert valid_out exactly 2 clk cycles after the rising edge that accepted the sample (stage 1: delay-line update; stage 2: multiply-accumulate plus round/saturate into the output register).
REQ-017 SHALL decimate by R: a modulo-R counter advances on each accepted sample; only the sample on which the counter equals 0 produces a valid_out pulse and updates y_output; all samples still enter the delay line.
REQ-018 SHALL treat R=0 as R=1; R=1 produces one output per accepted sample.
REQ-019 SHALL, on a change of R, restart the counter at 0 on the next accepted sample.
REQ-020 SHALL hold y_output at its last value between valid_out pulses; valid_out SHALL be low on all other cycles.
REQ-021 SHALL support back-to-back valid_in=1 every cycle at R=1 with one output per cycle (fully pipelined, throughput 1 sample/clk).

Reset
REQ-022 SHALL, while rst_n=1, asynchronously clear the delay line, pipeline registers and decimation counter to 0, y_output to 0 and valid_out to 0.
REQ-023 SHALL discard samples in flight when reset is asserted mid-stream; the first valid_out after reset release corresponds to the first sample accepted after release, 2 cycles later.

Verification
REQ-024 Reset mid-stream: rst_n=1 while valid_out pulses -> y_output=0x0000, valid_out=0 immediately (before next clk edge); after release, outputs use a zeroed history.
REQ-025 Impulse, R=1: x_input=0x4000 (0.5) for one sample, then 0x0000 continuously -> valid_out every cycle, y_output[k] = (h[k]*0x4000 + 2^14)>>>15 for k=0..91, then 0x0000.
REQ-026 DC step, R=1: x_input=0x4000 continuously from reset -> after 92 samples, y_output settles to sat(((sum h)*0x4000 + 2^14)>>>15) and stays constant.
REQ-027 Gapped input: valid_in toggles 1/0 each cycle with ramp samples -> valid_out pulses only 2 cycles after each valid_in=1 cycle; results identical to the gap-free run.
REQ-028 Decimation: R=4, 128 continuous valid samples -> exactly 32 valid_out pulses, spaced 4 cycles apart, values equal to every 4th output of the R=1 run starting with the first.
REQ-029 Saturation: ROM loaded with coefficient sum > 1.0 and x_input=0x7FFF continuously -> y_output=0x7FFF; x_input=0x8000 continuously -> y_output=0x8000.
